// File: rtl/stack_ctrl.sv
// stack_ctrl: sequencing controller for one register-file stack.
// Holds top-of-stack in a local register and tracks SP and element count.
// It turns single-cycle PUSH/POP/REPLACE commands into register-file
// accesses and raises sticky overflow/underflow flags.
// Optional build macro STACK_CTRL_WRAP_EN: the stack becomes circular.
// PUSH when full and POP when empty are then accepted instead of rejected.
module stack_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetq,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             err_clr,
    output logic [DEPTH-1:0] st_ra,
    input  logic [WIDTH-1:0] st_rd,
    output logic             st_we,
    output logic [DEPTH-1:0] st_wa,
    output logic [WIDTH-1:0] st_wd,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [DEPTH:0]   count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    // Capacity counts every RAM entry plus the TOS register.
    localparam logic [DEPTH:0] CAP = (DEPTH+1)'(2**DEPTH + 1);

    typedef enum logic [1:0] {
        OP_NOP     = 2'b00,
        OP_PUSH    = 2'b01,
        OP_POP     = 2'b10,
        OP_REPLACE = 2'b11
    } op_e;

    logic [DEPTH-1:0] r_sp;
    logic [WIDTH-1:0] r_tos;
    logic [DEPTH:0]   r_count;
    logic             r_ovf;
    logic             r_unf;

    op_e  w_op;
    logic w_full;
    logic w_empty;
    logic w_push;      // SP moves up, RAM written, TOS loads operand
    logic w_pop;       // SP moves down, TOS loads RAM read data
    logic w_repl;      // TOS loads operand only
    logic w_cnt_inc;
    logic w_cnt_dec;
    logic w_ovf_set;
    logic w_unf_set;

    assign w_op    = op_e'(cmd_op);
    assign w_full  = (r_count == CAP);
    assign w_empty = (r_count == '0);

    // Decode the command into accepted actions and error events.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_repl    = 1'b0;
        w_cnt_inc = 1'b0;
        w_cnt_dec = 1'b0;
        w_ovf_set = 1'b0;
        w_unf_set = 1'b0;
        if (cmd_valid) begin
            case (w_op)
                OP_PUSH: begin
`ifdef STACK_CTRL_WRAP_EN
                    // Circular: always accepted; the oldest entry is overwritten when full.
                    w_push    = 1'b1;
`else
                    w_push    = !w_full;
`endif
                    w_cnt_inc = !w_full;
                    w_ovf_set = w_full;
                end
                OP_POP: begin
`ifdef STACK_CTRL_WRAP_EN
                    // Circular: always accepted; count stays pinned at zero when empty.
                    w_pop     = 1'b1;
`else
                    w_pop     = !w_empty;
`endif
                    w_cnt_dec = !w_empty;
                    w_unf_set = w_empty;
                end
                OP_REPLACE: w_repl = 1'b1;
                default:    ;
            endcase
        end
    end

    // SP, TOS and count update on accepted commands.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_sp    <= '0;
            r_tos   <= '0;
            r_count <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (w_push) begin
                r_sp  <= r_sp + DEPTH'(1);
                r_tos <= cmd_data;
            end else if (w_pop) begin
                r_sp  <= r_sp - DEPTH'(1);
                r_tos <= st_rd;
            end else if (w_repl) begin
                r_tos <= cmd_data;
            end
            if (w_cnt_inc) begin
                r_count <= r_count + 1'b1;
            end else if (w_cnt_dec) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle beats err_clr.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_ovf_set)    r_ovf <= 1'b1;
            else if (err_clr) r_ovf <= 1'b0;
            if (w_unf_set)    r_unf <= 1'b1;
            else if (err_clr) r_unf <= 1'b0;
        end
    end

    // Register-file interface: read at SP, write one slot above it.
    // The write strobe is masked while reset is held.
    assign st_ra = r_sp;
    assign st_wa = r_sp + DEPTH'(1);
    assign st_wd = r_tos;
    assign st_we = w_push & resetq;

    assign tos   = r_tos;
    assign nos   = st_rd;
    assign count = r_count;
    assign empty = w_empty;
    assign full  = w_full;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: tb/tb_stack_ctrl.sv
// tb_stack_ctrl: directed bench for stack_ctrl with DEPTH=2 (CAP=5).
// A small register-file model sits on the st_* port.
// A reference stack model pushes the expected state to a queue for every command.
// That entry is popped and compared after the clock edge.
// Also covers the STACK_CTRL_WRAP_EN build.
module tb_stack_ctrl;

    localparam int W   = 32;
    localparam int D   = 2;
    localparam int CAP = 2**D + 1;
`ifdef STACK_CTRL_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] REPL = 2'b11;

    logic         clk = 1'b0;
    logic         resetq;
    logic         cmd_valid;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic         err_clr;
    logic [D-1:0] st_ra;
    logic [W-1:0] st_rd;
    logic         st_we;
    logic [D-1:0] st_wa;
    logic [W-1:0] st_wd;
    logic [W-1:0] tos;
    logic [W-1:0] nos;
    logic [D:0]   count;
    logic         empty;
    logic         full;
    logic         ovf;
    logic         unf;

    stack_ctrl #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .resetq(resetq),
        .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data), .err_clr(err_clr),
        .st_ra(st_ra), .st_rd(st_rd), .st_we(st_we), .st_wa(st_wa), .st_wd(st_wd),
        .tos(tos), .nos(nos), .count(count), .empty(empty), .full(full),
        .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    // Register file: synchronous write, combinational read.
    logic [W-1:0] ram [2**D];
    always @(posedge clk) if (st_we) ram[st_wa] <= st_wd;
    assign st_rd = ram[st_ra];

    // Reference model: m_stk holds entries below TOS, front = next-on-stack.
    logic [W-1:0] m_stk [$];
    logic [W-1:0] m_tos;
    bit           m_tos_ok;
    int           m_count;
    logic [D-1:0] m_sp;
    bit           m_ovf;
    bit           m_unf;

    typedef struct {
        logic [W-1:0] tos;
        bit           tos_ok;
        logic [W-1:0] nos;
        bit           nos_ok;
        int           count;
        logic [D-1:0] sp;
        bit           ovf;
        bit           unf;
    } exp_t;
    exp_t exp_q [$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_stk.delete();
        m_tos = '0; m_tos_ok = 1'b1;
        m_count = 0; m_sp = '0;
        m_ovf = 1'b0; m_unf = 1'b0;
        exp_q.delete();
    endtask

    // Drive one command for one cycle, predict, then compare after the edge.
    task automatic step(input bit v, input logic [1:0] op, input logic [W-1:0] d, input bit clr);
        exp_t         e;
        bit           is_full;
        bit           we_exp;
        logic [D-1:0] wa_exp;
        @(negedge clk);
        cmd_valid = v; cmd_op = op; cmd_data = d; err_clr = clr;
        #1;
        is_full = (m_count == CAP);
        we_exp  = v && (op == PUSH) && (WRAP || !is_full);
        wa_exp  = m_sp + 1'b1;
        check("st_we", W'(st_we), W'(we_exp));
        if (we_exp) begin
            check("st_wa", W'(st_wa), W'(wa_exp));
            if (m_tos_ok) check("st_wd", st_wd, m_tos);
        end
        if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
        if (v) begin
            case (op)
                PUSH: begin
                    if (!is_full) begin
                        if (m_count > 0) m_stk.push_front(m_tos);
                        m_tos = d; m_tos_ok = 1'b1;
                        m_count++; m_sp++;
                    end else begin
                        m_ovf = 1'b1;
                        if (WRAP) begin
                            m_stk.push_front(m_tos);
                            void'(m_stk.pop_back());
                            m_tos = d; m_sp++;
                        end
                    end
                end
                POP: begin
                    if (m_count > 0) begin
                        if (m_stk.size() > 0) m_tos = m_stk.pop_front();
                        else m_tos_ok = 1'b0;
                        m_count--; m_sp--;
                    end else begin
                        m_unf = 1'b1;
                        if (WRAP) begin m_sp--; m_tos_ok = 1'b0; end
                    end
                end
                REPL: begin m_tos = d; m_tos_ok = 1'b1; end
                default: ;
            endcase
        end
        e.tos = m_tos; e.tos_ok = m_tos_ok;
        e.nos_ok = (m_stk.size() > 0);
        e.nos = e.nos_ok ? m_stk[0] : '0;
        e.count = m_count; e.sp = m_sp; e.ovf = m_ovf; e.unf = m_unf;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.tos_ok) check("tos", tos, e.tos);
        if (e.nos_ok) check("nos", nos, e.nos);
        check("count", W'(count), W'(e.count));
        check("sp",    W'(st_ra), W'(e.sp));
        check("empty", W'(empty), W'(e.count == 0));
        check("full",  W'(full),  W'(e.count == CAP));
        check("ovf",   W'(ovf),   W'(e.ovf));
        check("unf",   W'(unf),   W'(e.unf));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a PUSH pending: nothing may be written.
        resetq = 1'b0; cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 'h5A; err_clr = 1'b0;
        model_reset();
        #3;
        check("rst_st_we", W'(st_we), '0);
        check("rst_count", W'(count), '0);
        check("rst_empty", W'(empty), W'(1));
        check("rst_full",  W'(full),  '0);
        check("rst_tos",   tos,       '0);
        check("rst_flags", W'({ovf, unf}), '0);
        repeat (2) @(negedge clk);
        resetq = 1'b1; cmd_valid = 1'b0; cmd_op = NOP;

        // 1: three pushes
        step(1, PUSH, 'h11, 0);
        step(1, PUSH, 'h22, 0);
        step(1, PUSH, 'h33, 0);
        check("t1_tos", tos, 'h33);
        check("t1_nos", nos, 'h22);

        // 2: two pops, no writes
        step(1, POP, '0, 0);
        step(1, POP, '0, 0);
        check("t2_tos", tos, 'h11);

        // 3: fill to capacity, one more push overflows
        step(1, POP, '0, 0);
        for (int i = 1; i <= 5; i++) step(1, PUSH, W'(i), 0);
        check("t3_full", W'(full), W'(1));
        step(1, PUSH, 'h6, 0);
        check("t3_ovf", W'(ovf), W'(1));
        step(0, NOP, '0, 1);

        // 4: drain, underflow, error beats clear, then clear
        for (int i = 0; i < 5; i++) step(1, POP, '0, 0);
        step(1, POP, '0, 0);
        step(1, POP, '0, 1);
        check("t4_unf", W'(unf), W'(1));
        step(0, NOP, '0, 1);

        // 5: replace keeps nos/count, invalid strobe changes nothing
        step(1, PUSH, 'h9, 0);
        step(1, PUSH, 'hA, 0);
        step(1, REPL, 'hB, 0);
        check("t5_tos", tos, 'hB);
        step(0, PUSH, 'hC, 0);
        check("t5_idle_tos", tos, 'hB);

        // 6: overflow at capacity, then async reset mid-burst
        for (int i = 0; i < 4; i++) step(1, PUSH, W'('h20 + i), 0);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = PUSH; cmd_data = 'h99;
        #2 resetq = 1'b0;
        #1;
        check("mid_rst_count", W'(count), '0);
        check("mid_rst_tos",   tos,       '0);
        check("mid_rst_flags", W'({ovf, unf}), '0);
        check("mid_rst_empty", W'(empty), W'(1));
        check("mid_rst_we",    W'(st_we), '0);
        check("mid_rst_sp",    W'(st_ra), '0);
        model_reset();
        @(negedge clk);
        resetq = 1'b1; cmd_valid = 1'b0;
        step(1, PUSH, 'h77, 0);
        step(1, PUSH, 'h78, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Sequencing controller for one `stack` register-file instance, for example a data or return stack.
- Keeps top-of-stack (TOS) in a local register. Keeps the stack pointer (SP) and the element count.
- Drives the register file's read address, write enable, write address and write data.
- Turns single-cycle PUSH/POP/REPLACE commands into legal register-file accesses and flags overflow/underflow.

Parameters:
- WIDTH, 32, data width; must equal the attached stack's WIDTH.
- DEPTH, 4, address bits; must equal the attached stack's DEPTH. RAM holds 2**DEPTH entries. Capacity CAP = 2**DEPTH+1, counting the TOS register.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetq  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command strobe; one command per cycle.
- cmd_op  in  2  00 NOP, 01 PUSH, 10 POP, 11 REPLACE.
- cmd_data  in  WIDTH  operand for PUSH/REPLACE.
- err_clr  in  1  clears the sticky ovf/unf flags.
- st_ra  out  DEPTH  register-file read address.
- st_rd  in  WIDTH  register-file read data (combinational).
- st_we  out  1  register-file write enable.
- st_wa  out  DEPTH  register-file write address.
- st_wd  out  WIDTH  register-file write data.
- tos  out  WIDTH  top of stack (registered).
- nos  out  WIDTH  next-on-stack; equals st_rd.
- count  out  DEPTH+1  elements held, 0..CAP.
- empty  out  1  count==0.
- full  out  1  count==CAP.
- ovf  out  1  sticky overflow flag.
- unf  out  1  sticky underflow flag.

Behaviour:
- Reset (resetq low, asynchronous): sp=0, tos=0, count=0, ovf=0, unf=0. Outputs during reset: st_we=0, empty=1, full=0.
- Combinational outputs:
  - st_ra=sp, nos=st_rd, st_wa=sp+1 (mod 2**DEPTH), st_wd=tos.
  - st_we=1 only for an accepted PUSH.
- Accept rule: a command is accepted when cmd_valid=1 and it is legal.
  - PUSH is illegal when full.
  - POP is illegal when empty.
  - NOP and REPLACE are always legal.
- Accepted PUSH: RAM[sp+1]<=tos; sp<=sp+1; tos<=cmd_data; count<=count+1.
  - A push from empty still writes and moves SP; the written value is don't-care, and this keeps SP movement uniform.
- Accepted POP: tos<=st_rd (old RAM[sp]); sp<=sp-1; count<=count-1.
  - A pop to count 0 leaves tos holding a don't-care value.
- Accepted REPLACE: tos<=cmd_data; sp, count and RAM unchanged.
- NOP, or cmd_valid=0: no state change.
- Rejected PUSH (full): no state change, st_we=0, ovf<=1.
- Rejected POP (empty): no state change, unf<=1.
- Latency:
  - tos/count/sp reflect a command on the next cycle.
  - nos reflects the new SP in the same cycle SP updates, because the RAM read is combinational.
- Flags:
  - ovf and unf hold until err_clr=1.
  - err_clr in the same cycle as a new error: the error wins and the flag stays 1.
- Arithmetic: SP is DEPTH bits and wraps modulo 2**DEPTH. count never leaves 0..CAP.
- Reset asserted mid-sequence: state returns to reset values immediately; RAM contents are not cleared.

Optional Feature:
- Macro: STACK_CTRL_WRAP_EN.
- Defined (circular stack):
  - PUSH when full is accepted: write, SP increments, tos updates, count stays CAP (oldest entry lost), ovf<=1.
  - POP when empty is accepted: tos<=st_rd, SP decrements, count stays 0, unf<=1.
- Undefined: reject behaviour exactly as in Behaviour.

Test Plan (DEPTH=2, CAP=5):
1. Reset, then PUSH 0x11, 0x22, 0x33 in consecutive cycles -> tos=0x33, nos=0x22, count=3, sp=3, ovf=0/unf=0.
2. From (1), POP, POP -> tos=0x22 then 0x11; count=1; no st_we during pops.
3. PUSH 0x1..0x5, then PUSH 0x6 -> count=5, full=1, 0x6 rejected (st_we=0), tos=0x5, ovf=1. Then err_clr -> ovf=0.
4. From empty, POP -> unf=1, count=0, sp unchanged. The same cycle's err_clr with a second POP -> unf stays 1.
5. Start with count=2, tos=0xA. REPLACE 0xB -> tos=0xB, count=2, nos unchanged. Then PUSH 0xC with cmd_valid=0 -> no change.
6. With STACK_CTRL_WRAP_EN and a full stack, PUSH 0x6 -> tos=0x6, count=5, sp wrapped, ovf=1. Reset asserted mid-burst -> count=0, tos=0, flags 0 asynchronously.
